valu_elem_sequencer: RTL and testbench

//  Issue-side driver for the vector ALU. Accepts one decoded vector arithmetic

---
 rtl/valu_pkg.sv | 45 ++++
 rtl/valu_elem_sequencer.sv | 170 +++++++++++++++++
 tb/tb_valu_elem_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// valu_pkg: op codes, operand-source codes and FSM states for the vector ALU sequencer (rev 1.0)
`default_nettype none

package valu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_RSUB  = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_MSEQ  = 5'd9;
  localparam logic [4:0] OP_MSNE  = 5'd10;
  localparam logic [4:0] OP_MSLTU = 5'd11;
  localparam logic [4:0] OP_MSLT  = 5'd12;
  localparam logic [4:0] OP_MSLEU = 5'd13;
  localparam logic [4:0] OP_MSLE  = 5'd14;
  localparam logic [4:0] OP_MSGTU = 5'd15;
  localparam logic [4:0] OP_MSGT  = 5'd16;
  localparam logic [4:0] OP_MINU  = 5'd17;
  localparam logic [4:0] OP_MIN   = 5'd18;
  localparam logic [4:0] OP_MAXU  = 5'd19;
  localparam logic [4:0] OP_MAX   = 5'd20;
  localparam logic [4:0] OP_MERGE = 5'd21;

  localparam logic [1:0] SRC_VV = 2'b00;
  localparam logic [1:0] SRC_VX = 2'b01;
  localparam logic [1:0] SRC_VI = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic is_cmp(input logic [4:0] op);
    return (op >= OP_MSEQ) && (op <= OP_MSGT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/valu_elem_sequencer.sv
// valu_elem_sequencer: steps one vector ALU instruction through its elements, R -> E -> W (rev 1.0)
`default_nettype none

module valu_elem_sequencer
  import valu_pkg::*;
#(
  parameter int VLMAX  = 32,
  parameter int ELEN   = 32,
  parameter int RIDX_W = 5,
  parameter int EIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        issue_op,
  input  logic [1:0]        issue_src,
  input  logic [RIDX_W-1:0] issue_vd,
  input  logic [RIDX_W-1:0] issue_vs1,
  input  logic [RIDX_W-1:0] issue_vs2,
  input  logic [ELEN-1:0]   issue_scalar,
  input  logic              issue_vm,
  input  logic [EIDX_W:0]   issue_vl,
  input  logic [VLMAX-1:0]  mask_in,
  output logic              rd_en,
  output logic [RIDX_W-1:0] rd_vs1,
  output logic [RIDX_W-1:0] rd_vs2,
  output logic [EIDX_W-1:0] rd_eidx,
  input  logic [ELEN-1:0]   rd_vs1_data,
  input  logic [ELEN-1:0]   rd_vs2_data,
  output logic [ELEN-1:0]   alu_opd1,
  output logic [ELEN-1:0]   alu_opd2,
  output logic [4:0]        alu_op,
  output logic              alu_vm,
  input  logic [ELEN-1:0]   alu_result,
  output logic              wr_en,
  output logic [RIDX_W-1:0] wr_reg,
  output logic [EIDX_W-1:0] wr_eidx,
  output logic [ELEN-1:0]   wr_data,
  output logic              mwr_en,
  output logic [RIDX_W-1:0] mwr_reg,
  output logic [VLMAX-1:0]  mwr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [EIDX_W:0] VLMAX_W = (EIDX_W+1)'(VLMAX);

  state_t              state;
  logic [4:0]          op_q;
  logic                cmp_q;
  logic                scalar_sel;
  logic [RIDX_W-1:0]   vd_q;
  logic [ELEN-1:0]     scalar_q;
  logic                vm_q;
  logic [VLMAX-1:0]    mask_q;
  logic [EIDX_W-1:0]   last_idx;
  logic [EIDX_W-1:0]   cnt;
  logic                any_elem;
  logic                e_valid;
  logic [EIDX_W-1:0]   e_eidx;
  logic [VLMAX-1:0]    mask_acc;

  logic [EIDX_W:0]     vl_eff;
  logic                elem_vm;

  assign vl_eff  = (issue_vl > VLMAX_W) ? VLMAX_W : issue_vl;
  assign elem_vm = vm_q | mask_q[e_eidx];

  // E stage: VRF data arrives the cycle after rd_en, ALU sees it combinationally
  assign alu_opd1 = e_valid ? rd_vs2_data : '0;
  assign alu_opd2 = e_valid ? (scalar_sel ? scalar_q : rd_vs1_data) : '0;
  assign alu_op   = e_valid ? op_q : '0;
  assign alu_vm   = e_valid & elem_vm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_vs1      <= '0;
      rd_vs2      <= '0;
      rd_eidx     <= '0;
      wr_en       <= 1'b0;
      wr_reg      <= '0;
      wr_eidx     <= '0;
      wr_data     <= '0;
      mwr_en      <= 1'b0;
      mwr_reg     <= '0;
      mwr_data    <= '0;
      op_q        <= '0;
      cmp_q       <= 1'b0;
      scalar_sel  <= 1'b0;
      vd_q        <= '0;
      scalar_q    <= '0;
      vm_q        <= 1'b0;
      mask_q      <= '0;
      last_idx    <= '0;
      cnt         <= '0;
      any_elem    <= 1'b0;
      e_valid     <= 1'b0;
      e_eidx      <= '0;
      mask_acc    <= '0;
    end else begin
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      mwr_en  <= 1'b0;
      e_valid <= rd_en;
      e_eidx  <= rd_eidx;

      if (e_valid) begin
        if (cmp_q) begin
          mask_acc[e_eidx] <= elem_vm & alu_result[0];
        end else if (elem_vm || (op_q == OP_MERGE)) begin
          wr_en   <= 1'b1;
          wr_reg  <= vd_q;
          wr_eidx <= e_eidx;
          wr_data <= alu_result;
        end
      end

      case (state)
        IDLE: begin
          if (issue_valid) begin
            op_q        <= issue_op;
            cmp_q       <= is_cmp(issue_op);
            scalar_sel  <= (issue_src == SRC_VX) || (issue_src == SRC_VI);
            vd_q        <= issue_vd;
            rd_vs1      <= issue_vs1;
            rd_vs2      <= issue_vs2;
            scalar_q    <= issue_scalar;
            vm_q        <= issue_vm;
            mask_q      <= mask_in;
            last_idx    <= EIDX_W'(vl_eff - 1'b1);
            any_elem    <= (vl_eff != '0);
            cnt         <= '0;
            mask_acc    <= '0;
            issue_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= (vl_eff == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          rd_en   <= 1'b1;
          rd_eidx <= cnt;
          cnt     <= cnt + 1'b1;
          if (cnt == last_idx) state <= DRAIN;
        end
        DRAIN: begin
          if (!rd_en && !e_valid) begin
            done        <= 1'b1;
            mwr_en      <= cmp_q & any_elem;
            mwr_reg     <= vd_q;
            mwr_data    <= mask_acc;
            issue_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_valu_elem_sequencer.sv
// tb_valu_elem_sequencer: directed checks of valu_elem_sequencer with a VRF and ALU model (rev 1.0)
`default_nettype none

module tb_valu_elem_sequencer;
  import valu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_op;
  logic [1:0]  issue_src;
  logic [4:0]  issue_vd, issue_vs1, issue_vs2;
  logic [31:0] issue_scalar;
  logic        issue_vm;
  logic [5:0]  issue_vl;
  logic [31:0] mask_in;
  logic        rd_en;
  logic [4:0]  rd_vs1, rd_vs2, rd_eidx;
  logic [31:0] rd_vs1_data = '0, rd_vs2_data = '0;
  logic [31:0] alu_opd1, alu_opd2, alu_result;
  logic [4:0]  alu_op;
  logic        alu_vm;
  logic        wr_en;
  logic [4:0]  wr_reg, wr_eidx;
  logic [31:0] wr_data;
  logic        mwr_en;
  logic [4:0]  mwr_reg;
  logic [31:0] mwr_data;
  logic        busy, done;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] vrf [32][32];
  logic [31:0] exp_wd [40];
  logic [39:0] exp_wen;
  logic [31:0] exp_mask;

  valu_elem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_src(issue_src), .issue_vd(issue_vd), .issue_vs1(issue_vs1),
    .issue_vs2(issue_vs2), .issue_scalar(issue_scalar), .issue_vm(issue_vm),
    .issue_vl(issue_vl), .mask_in(mask_in),
    .rd_en(rd_en), .rd_vs1(rd_vs1), .rd_vs2(rd_vs2), .rd_eidx(rd_eidx),
    .rd_vs1_data(rd_vs1_data), .rd_vs2_data(rd_vs2_data),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_op(alu_op), .alu_vm(alu_vm),
    .alu_result(alu_result),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_eidx(wr_eidx), .wr_data(wr_data),
    .mwr_en(mwr_en), .mwr_reg(mwr_reg), .mwr_data(mwr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read VRF: data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) begin
      rd_vs1_data <= vrf[rd_vs1][rd_eidx];
      rd_vs2_data <= vrf[rd_vs2][rd_eidx];
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:   alu_result = alu_opd1 + alu_opd2;
      OP_SUB:   alu_result = alu_opd1 - alu_opd2;
      OP_RSUB:  alu_result = alu_opd2 - alu_opd1;
      OP_MSLT:  alu_result = {31'b0, $signed(alu_opd1) < $signed(alu_opd2)};
      OP_MERGE: alu_result = alu_vm ? alu_opd2 : alu_opd1;
      default:  alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [1:0] src, input logic [4:0] vd,
                       input logic [4:0] vs1, input logic [4:0] vs2, input logic [31:0] sc,
                       input logic vm, input logic [5:0] vl, input logic [31:0] msk);
    @(negedge clk);
    chk("issue_ready_before_accept", issue_ready, 1);
    issue_valid = 1'b1; issue_op = op; issue_src = src; issue_vd = vd;
    issue_vs1 = vs1; issue_vs2 = vs2; issue_scalar = sc; issue_vm = vm;
    issue_vl = vl; mask_in = msk;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  // Walks cycles T+1 .. done, checking read, write, done and mask-write timing
  task automatic run(input int vl, input logic [4:0] vd, input logic [4:0] vs1,
                     input logic [4:0] vs2, input logic cmp);
    int done_k;
    done_k = (vl == 0) ? 1 : vl + 3;
    for (int k = 1; k <= done_k; k++) begin
      logic exp_rd, exp_wr, exp_mw;
      @(negedge clk);
      exp_rd = (k >= 1) && (k <= vl);
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        chk("rd_eidx", rd_eidx, k - 1);
        chk("rd_vs1", rd_vs1, vs1);
        chk("rd_vs2", rd_vs2, vs2);
      end
      exp_wr = (k >= 3) && (k <= vl + 2) && !cmp && exp_wen[k-3];
      chk("wr_en", wr_en, exp_wr);
      if (exp_wr) begin
        chk("wr_eidx", wr_eidx, k - 3);
        chk("wr_reg", wr_reg, vd);
        chk("wr_data", wr_data, exp_wd[k-3]);
      end
      chk("done", done, k == done_k);
      exp_mw = (k == done_k) && cmp && (vl > 0);
      chk("mwr_en", mwr_en, exp_mw);
      if (exp_mw) begin
        chk("mwr_reg", mwr_reg, vd);
        chk("mwr_data", mwr_data, exp_mask);
      end
      chk("busy", busy, k < done_k);
      chk("issue_ready", issue_ready, k >= done_k);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_issue_ready"}, issue_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_mwr_en"}, mwr_en, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_alu_opd1"}, alu_opd1, 0);
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_src = '0; issue_vd = '0;
    issue_vs1 = '0; issue_vs2 = '0; issue_scalar = '0; issue_vm = 1'b0;
    issue_vl = '0; mask_in = '0;
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 32; e++) vrf[r][e] = '0;
    vrf[2][0] = 1;  vrf[2][1] = 2;  vrf[2][2] = 3;  vrf[2][3] = 4;
    vrf[1][0] = 10; vrf[1][1] = 20; vrf[1][2] = 30; vrf[1][3] = 40;
    vrf[5][0] = 50; vrf[5][1] = 60; vrf[5][2] = 70; vrf[5][3] = 80;
    vrf[6][0] = 1;  vrf[6][1] = 2;  vrf[6][2] = 3;  vrf[6][3] = 4;
    vrf[7][0] = 32'hFFFF_FFFF; vrf[7][1] = 0; vrf[7][2] = 1; vrf[7][3] = 2;
    vrf[7][4] = 32'hFFFF_FFFB;
    vrf[9][0] = 7; vrf[9][1] = 8;
    for (int e = 0; e < 32; e++) begin
      vrf[10][e] = e;
      vrf[11][e] = 2 * e;
    end

    repeat (3) @(negedge clk);
    chk("reset_rd_vs1", rd_vs1, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_mwr_data", mwr_data, 0);
    chk_quiet("reset");
    rst_n = 1'b1;

    // vadd.vv vl=4
    exp_wd[0] = 11; exp_wd[1] = 22; exp_wd[2] = 33; exp_wd[3] = 44;
    exp_wen = 40'hF; exp_mask = '0;
    issue(OP_ADD, SRC_VV, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 6'd4, 32'd0);
    run(4, 5'd3, 5'd1, 5'd2, 1'b0);

    // vrsub.vx x=100 vl=2
    exp_wd[0] = 99; exp_wd[1] = 98; exp_wen = 40'h3;
    issue(OP_RSUB, SRC_VX, 5'd4, 5'd0, 5'd2, 32'd100, 1'b1, 6'd2, 32'd0);
    run(2, 5'd4, 5'd0, 5'd2, 1'b0);

    // vsub.vv masked, v0=0101
    exp_wd[0] = 49; exp_wd[2] = 67; exp_wen = 40'h5;
    issue(OP_SUB, SRC_VV, 5'd13, 5'd6, 5'd5, 32'd0, 1'b0, 6'd4, 32'h5);
    run(4, 5'd13, 5'd6, 5'd5, 1'b0);

    // vmslt.vx x=1 vl=5
    exp_wen = '0; exp_mask = 32'b10011;
    issue(OP_MSLT, SRC_VX, 5'd8, 5'd0, 5'd7, 32'd1, 1'b1, 6'd5, 32'd0);
    run(5, 5'd8, 5'd0, 5'd7, 1'b1);

    // vmerge.vim imm=-3, v0=10
    exp_wd[0] = 7; exp_wd[1] = 32'hFFFF_FFFD; exp_wen = 40'h3;
    issue(OP_MERGE, SRC_VI, 5'd14, 5'd0, 5'd9, 32'hFFFF_FFFD, 1'b0, 6'd2, 32'h2);
    run(2, 5'd14, 5'd0, 5'd9, 1'b0);

    // vl=0 on a compare: done next cycle, nothing else
    exp_wen = '0; exp_mask = '0;
    issue(OP_MSLT, SRC_VX, 5'd8, 5'd0, 5'd7, 32'd1, 1'b1, 6'd0, 32'd0);
    run(0, 5'd8, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    chk_quiet("after_vl0");

    // vl=40 clamps to 32
    for (int e = 0; e < 32; e++) exp_wd[e] = 3 * e;
    exp_wen = 40'hFF_FFFF_FFFF;
    issue(OP_ADD, SRC_VV, 5'd12, 5'd11, 5'd10, 32'd0, 1'b1, 6'd40, 32'd0);
    run(32, 5'd12, 5'd11, 5'd10, 1'b0);

    // reset during vl=8
    issue(OP_ADD, SRC_VV, 5'd15, 5'd1, 5'd2, 32'd0, 1'b1, 6'd8, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midop_rd_en_before_reset", rd_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_wr_data", wr_data, 0);
    chk("midop_rd_eidx", rd_eidx, 0);
    chk_quiet("midop_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_reset_wr_en", wr_en, 0);
      chk("post_reset_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
